// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
//   Shared types and constants for the data-port arbiter between the four
//   cores and the single data port of mem.
//
//   NCORES      number of request channels (fixed at 4)
//   RD_LAT_MAX  largest supported memory read latency
//   core_id_t   2-bit core index
//   tag_t       {valid, core_id} carried alongside an outstanding load
//   core_onehot helper turning a core index into a one-hot core vector
// -----------------------------------------------------------------------------
package mem_arb_pkg;

   localparam int NCORES     = 4;
   localparam int RD_LAT_MAX = 4;

   typedef logic [1:0] core_id_t;

   typedef struct packed {
      logic     valid;
      core_id_t core_id;
   } tag_t;

   function automatic logic [NCORES-1:0] core_onehot(input core_id_t id);
      logic [NCORES-1:0] oh;
      oh     = '0;
      oh[id] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/rr_pick4.sv
// -----------------------------------------------------------------------------
// rr_pick4
//   Combinational 4-way round-robin picker. Scans the eligible mask starting
//   at the pointer position and wrapping modulo 4; the first set bit wins.
//
//   elig_i  eligible requesters
//   ptr_i   round-robin start position
//   gnt_o   one-hot grant (all zero when nothing is eligible)
//   idx_o   index of the granted requester (0 when nothing is eligible)
// -----------------------------------------------------------------------------
module rr_pick4
   import mem_arb_pkg::*;
(
   input  logic [NCORES-1:0] elig_i,
   input  core_id_t          ptr_i,
   output logic [NCORES-1:0] gnt_o,
   output core_id_t          idx_o
);

   logic     found;
   core_id_t cand;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      cand  = ptr_i;
      for (int unsigned k = 0; k < NCORES; k++) begin
         // core_id_t arithmetic wraps naturally modulo 4
         cand = ptr_i + core_id_t'(k);
         if (!found && elig_i[cand]) begin
            gnt_o[cand] = 1'b1;
            idx_o       = cand;
            found       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares the single data port of mem between four cores. Each core has a
//   valid/ready request channel; one request is granted per cycle in
//   round-robin order among cores that are both requesting and running.
//   The granted request is registered into the issue stage, which drives the
//   memory read or write strobe for one cycle. Loads carry a tag through a
//   RD_LAT-deep pipe so the returning mem_rdata is routed to the right core.
//
//   Optional feature: define MEM_ARB_WPRIO_EN to give stores priority over
//   loads (stores round-robin among themselves, loads only win when no store
//   is eligible; both classes share one pointer).
//
//   Ports
//     clk, reset            clock, synchronous active-high reset
//     run_mask              per-core run enable (pauseResume bits)
//     req_valid/write       per-core request and store(1)/load(0) flag
//     req_addr/req_wdata    packed per-core address/store data
//     req_ready             one-hot grant, combinational
//     resp_valid/resp_data  one-hot load return and its data
//     mem_ren/mem_raddr     memory read port
//     mem_wen/mem_waddr/
//     mem_wdata             memory write port
//     mem_rdata             memory read data, RD_LAT cycles after mem_ren
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int NCORES = 4,
   parameter int AW     = 15,
   parameter int DW     = 16,
   parameter int RD_LAT = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NCORES-1:0]    run_mask,
   input  logic [NCORES-1:0]    req_valid,
   input  logic [NCORES-1:0]    req_write,
   input  logic [NCORES*AW-1:0] req_addr,
   input  logic [NCORES*DW-1:0] req_wdata,
   output logic [NCORES-1:0]    req_ready,
   output logic [NCORES-1:0]    resp_valid,
   output logic [DW-1:0]        resp_data,
   output logic                 mem_ren,
   output logic [AW-1:0]        mem_raddr,
   output logic                 mem_wen,
   output logic [AW-1:0]        mem_waddr,
   output logic [DW-1:0]        mem_wdata,
   input  logic [DW-1:0]        mem_rdata
);

   import mem_arb_pkg::*;

   // ---------------------------------------------------------------- arbitration
   logic [NCORES-1:0] elig;
   logic [NCORES-1:0] cand;
   logic [NCORES-1:0] gnt;
   core_id_t          gnt_idx;
   logic              gnt_any;
   core_id_t          rr_ptr_q;

   always_comb begin
      elig = req_valid & run_mask;
      cand = elig;
`ifdef MEM_ARB_WPRIO_EN
      // any eligible store shuts loads out of this cycle's competition
      if (|(elig & req_write)) begin
         cand = elig & req_write;
      end
`else
`endif
   end

   rr_pick4 u_pick (
      .elig_i (cand),
      .ptr_i  (rr_ptr_q),
      .gnt_o  (gnt),
      .idx_o  (gnt_idx)
   );

   assign req_ready = reset ? '0 : gnt;
   assign gnt_any   = |gnt & ~reset;

   // ---------------------------------------------------------- granted request
   logic          sel_write;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wdata;

   always_comb begin
      sel_write = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int unsigned i = 0; i < NCORES; i++) begin
         if (gnt[i]) begin
            sel_write = req_write[i];
            sel_addr  = req_addr[i*AW +: AW];
            sel_wdata = req_wdata[i*DW +: DW];
         end
      end
   end

   // ------------------------------------------------------- issue register next
   logic          ren_d,   ren_q;
   logic          wen_d,   wen_q;
   logic [AW-1:0] raddr_d, raddr_q;
   logic [AW-1:0] waddr_d, waddr_q;
   logic [DW-1:0] wdata_d, wdata_q;
   core_id_t      issue_core_d, issue_core_q;
   core_id_t      rr_ptr_d;

   always_comb begin
      ren_d        = gnt_any & ~sel_write;
      wen_d        = gnt_any & sel_write;
      // address/data lines idle at zero when their strobe is low
      raddr_d      = ren_d ? sel_addr  : '0;
      waddr_d      = wen_d ? sel_addr  : '0;
      wdata_d      = wen_d ? sel_wdata : '0;
      issue_core_d = gnt_idx;
      rr_ptr_d     = gnt_any ? core_id_t'(gnt_idx + 2'd1) : rr_ptr_q;
   end

   // ------------------------------------------------------ tag pipe / response
   tag_t              pipe_q [RD_LAT];
   tag_t              tag_exit;
   logic [NCORES-1:0] resp_valid_d, resp_valid_q;
   logic [DW-1:0]     resp_data_d,  resp_data_q;

   // the issue stage holds the load during the cycle mem_ren is high, so the
   // tag enters the pipe then and exits exactly when mem_rdata is valid
   assign tag_exit = pipe_q[RD_LAT-1];

   always_comb begin
      resp_valid_d = '0;
      resp_data_d  = resp_data_q;
      if (tag_exit.valid) begin
         resp_valid_d = core_onehot(tag_exit.core_id);
         resp_data_d  = mem_rdata;
      end
   end

   // ------------------------------------------------------------------ state
   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr_q     <= '0;
         ren_q        <= 1'b0;
         wen_q        <= 1'b0;
         raddr_q      <= '0;
         waddr_q      <= '0;
         wdata_q      <= '0;
         issue_core_q <= '0;
         for (int unsigned i = 0; i < RD_LAT; i++) begin
            pipe_q[i] <= '0;
         end
         resp_valid_q <= '0;
         resp_data_q  <= '0;
      end else begin
         rr_ptr_q     <= rr_ptr_d;
         ren_q        <= ren_d;
         wen_q        <= wen_d;
         raddr_q      <= raddr_d;
         waddr_q      <= waddr_d;
         wdata_q      <= wdata_d;
         issue_core_q <= issue_core_d;
         pipe_q[0]    <= '{valid: ren_q, core_id: issue_core_q};
         for (int unsigned i = 1; i < RD_LAT; i++) begin
            pipe_q[i] <= pipe_q[i-1];
         end
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
      end
   end

   assign mem_ren    = ren_q;
   assign mem_raddr  = raddr_q;
   assign mem_wen    = wen_q;
   assign mem_waddr  = waddr_q;
   assign mem_wdata  = wdata_q;
   assign resp_valid = resp_valid_q;
   assign resp_data  = resp_data_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

   localparam int NC     = 4;
   localparam int AW     = 15;
   localparam int DW     = 16;
   localparam int RD_LAT = 3;

   logic              clk = 1'b0;
   logic              reset;
   logic [NC-1:0]     run_mask;
   logic [NC-1:0]     req_valid, req_write, req_ready, resp_valid;
   logic [NC*AW-1:0]  req_addr;
   logic [NC*DW-1:0]  req_wdata;
   logic [DW-1:0]     resp_data, mem_wdata, mem_rdata;
   logic              mem_ren, mem_wen;
   logic [AW-1:0]     mem_raddr, mem_waddr;

   mem_port_arbiter #(
      .NCORES (NC),
      .AW     (AW),
      .DW     (DW),
      .RD_LAT (RD_LAT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .run_mask   (run_mask),
      .req_valid  (req_valid),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_data  (resp_data),
      .mem_ren    (mem_ren),
      .mem_raddr  (mem_raddr),
      .mem_wen    (mem_wen),
      .mem_waddr  (mem_waddr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   always #5 clk = ~clk;

   // ------------------------------------------------------------ bookkeeping
   int          checks = 0;
   int          errors = 0;
   int unsigned cyc    = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: cycle %0d got 0x%0h expected 0x%0h", name, cyc, got, exp);
      end
   endtask

   // ---------------------------------------------------------- requester state
   logic [NC-1:0] pend_v  = '0;
   logic [NC-1:0] pend_wr = '0;
   logic [AW-1:0] pend_addr [NC];
   logic [DW-1:0] pend_wd   [NC];

   assign req_valid = pend_v;
   assign req_write = pend_wr;
   for (genvar g = 0; g < NC; g++) begin : g_pack
      assign req_addr[g*AW +: AW]  = pend_addr[g];
      assign req_wdata[g*DW +: DW] = pend_wd[g];
   end

   // ------------------------------------------- environment memory (the "mem")
   logic [DW-1:0] env_mem [0:(1<<AW)-1];
   logic [DW-1:0] ref_mem [0:(1<<AW)-1];
   logic [DW-1:0] dl [RD_LAT];

   always @(posedge clk) begin
      if (mem_wen === 1'b1) env_mem[mem_waddr] = mem_wdata;
      for (int i = RD_LAT-1; i > 0; i--) dl[i] = dl[i-1];
      dl[0] = (mem_ren === 1'b1) ? env_mem[mem_raddr] : DW'($urandom);
      mem_rdata <= dl[RD_LAT-1];
   end

   // ------------------------------------------------------- reference model
   typedef struct {
      int unsigned   due;
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } iss_t;

   typedef struct {
      int unsigned   due;
      int            core;
      logic [DW-1:0] data;
   } rsp_t;

   iss_t iss_q[$];
   rsp_t rsp_q[$];
   int   m_ptr        = 0;
   int   granted_core = -1;

   always @(posedge clk) begin
      cyc++;
      if (reset === 1'b1) begin
         iss_q.delete();
         rsp_q.delete();
         m_ptr = 0;
      end
   end

   always @(negedge clk) begin : model
      int            win;
      int            c;
      logic [NC-1:0] elig, cand, exp_rdy;
      win  = -1;
      elig = pend_v & run_mask;
      cand = elig;
`ifdef MEM_ARB_WPRIO_EN
      if ((elig & pend_wr) != '0) cand = elig & pend_wr;
`endif
      if (reset !== 1'b1) begin
         for (int k = 0; k < NC; k++) begin
            c = (m_ptr + k) % NC;
            if (win < 0 && cand[c]) win = c;
         end
      end
      exp_rdy = '0;
      if (win >= 0) exp_rdy[win] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      granted_core = win;
      if (win >= 0) begin
         m_ptr = (win + 1) % NC;
         if (pend_wr[win]) begin
            ref_mem[pend_addr[win]] = pend_wd[win];
            iss_q.push_back('{cyc + 1, 1'b1, pend_addr[win], pend_wd[win]});
         end else begin
            iss_q.push_back('{cyc + 1, 1'b0, pend_addr[win], '0});
            rsp_q.push_back('{cyc + 2 + RD_LAT, win, ref_mem[pend_addr[win]]});
         end
      end
   end

   // ----------------------------------------------------------------- monitor
   always @(negedge clk) begin : monitor
      iss_t e;
      rsp_t r;
      if (mem_ren === 1'b1 || mem_wen === 1'b1) begin
         if (iss_q.size() == 0) begin
            chk("strobe_unexpected", {30'd0, mem_wen, mem_ren}, 32'd0);
         end else begin
            e = iss_q.pop_front();
            chk("issue_cycle", cyc, e.due);
            chk("issue_kind", {30'd0, mem_wen, mem_ren}, e.wr ? 32'd2 : 32'd1);
            if (e.wr) begin
               chk("mem_waddr", 32'(mem_waddr), 32'(e.addr));
               chk("mem_wdata", 32'(mem_wdata), 32'(e.data));
            end else begin
               chk("mem_raddr", 32'(mem_raddr), 32'(e.addr));
            end
         end
      end else if (iss_q.size() != 0 && iss_q[0].due <= cyc) begin
         e = iss_q.pop_front();
         chk("issue_missing", {30'd0, mem_wen, mem_ren}, e.wr ? 32'd2 : 32'd1);
      end

      if (resp_valid !== '0) begin
         if (rsp_q.size() == 0) begin
            chk("resp_unexpected", 32'(resp_valid), 32'd0);
         end else begin
            r = rsp_q.pop_front();
            chk("resp_cycle", cyc, r.due);
            chk("resp_valid", 32'(resp_valid), 32'd1 << r.core);
            chk("resp_data", 32'(resp_data), 32'(r.data));
         end
      end else if (rsp_q.size() != 0 && rsp_q[0].due <= cyc) begin
         r = rsp_q.pop_front();
         chk("resp_missing", 32'(resp_valid), 32'd1 << r.core);
      end
   end

   // ---------------------------------------------------------------- stimulus
   int mode = 0;  // 0 manual, 1 all cores loading continuously, 2 random

   task automatic new_req(input int c, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      pend_v[c]    = 1'b1;
      pend_wr[c]   = w;
      pend_addr[c] = a;
      pend_wd[c]   = d;
   endtask

   task automatic refill();
      for (int c = 0; c < NC; c++) begin
         if (mode == 1 && !pend_v[c]) begin
            new_req(c, 1'b0, AW'($urandom_range(0, 63)), '0);
         end else if (mode == 2) begin
            if (!pend_v[c] && $urandom_range(0, 2) == 0)
               new_req(c, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom));
            else if (pend_v[c] && $urandom_range(0, 31) == 0)
               pend_v[c] = 1'b0;
         end
      end
      if (mode == 2 && $urandom_range(0, 15) == 0) run_mask = NC'($urandom_range(0, 15));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (granted_core >= 0) pend_v[granted_core] = 1'b0;
      refill();
   endtask

   task automatic do_reset();
      pend_v = '0;
      mode   = 0;
      reset  = 1'b1;
      tick();
      reset  = 1'b0;
   endtask

   task automatic chk_regs_zero(input string tag);
      chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
      chk({tag, "_resp_data"},  32'(resp_data),  32'd0);
      chk({tag, "_mem_ren"},    32'(mem_ren),    32'd0);
      chk({tag, "_mem_raddr"},  32'(mem_raddr),  32'd0);
      chk({tag, "_mem_wen"},    32'(mem_wen),    32'd0);
      chk({tag, "_mem_waddr"},  32'(mem_waddr),  32'd0);
      chk({tag, "_mem_wdata"},  32'(mem_wdata),  32'd0);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin : stim
      logic        found;
      int unsigned t0;
      logic [DW-1:0] v;

      for (int i = 0; i < (1 << AW); i++) begin
         v = DW'($urandom);
         env_mem[i] = v;
         ref_mem[i] = v;
      end
      env_mem[16'h0010] = 16'hBEEF;
      ref_mem[16'h0010] = 16'hBEEF;
      for (int c = 0; c < NC; c++) begin
         pend_addr[c] = '0;
         pend_wd[c]   = '0;
      end
      reset    = 1'b1;
      run_mask = '0;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_req_ready", 32'(req_ready), 32'd0);
      chk_regs_zero("reset");
      @(posedge clk);
      #1;
      reset    = 1'b0;
      run_mask = '1;

      // single load from core 2
      new_req(2, 1'b0, 15'h0010, '0);
      @(negedge clk);
      chk("single_load_ready", 32'(req_ready), 32'b0100);
      t0    = cyc;
      found = 1'b0;
      for (int k = 0; k < 12 && !found; k++) begin
         tick();
         @(negedge clk);
         if (resp_valid !== '0) begin
            found = 1'b1;
            chk("single_load_latency", cyc - t0, 2 + RD_LAT);
            chk("single_load_resp_valid", 32'(resp_valid), 32'b0100);
            chk("single_load_data", 32'(resp_data), 32'hBEEF);
         end
      end
      chk("single_load_seen", 32'(found), 32'd1);
      tick();

      // contention: all four cores loading continuously from reset
      do_reset();
      mode = 1;
      refill();
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         chk("contention_order", 32'(req_ready), 32'd1 << (k % 4));
         tick();
      end

      // masking core 1
      do_reset();
      mode     = 1;
      run_mask = 4'b1101;
      refill();
      repeat (12) tick();
      run_mask = 4'b1111;
      found    = 1'b0;
      for (int k = 0; k < 4 && !found; k++) begin
         @(negedge clk);
         if (req_ready[1] === 1'b1) found = 1'b1;
         tick();
      end
      chk("mask_release_grant", 32'(found), 32'd1);
      mode = 0;
      pend_v = '0;
      repeat (8) tick();

      // load and store in the same cycle
      do_reset();
      run_mask = '1;
      new_req(0, 1'b0, 15'h0020, '0);
      new_req(3, 1'b1, 15'h0020, 16'h1234);
      @(negedge clk);
`ifdef MEM_ARB_WPRIO_EN
      chk("wprio_first", 32'(req_ready), 32'b1000);
`else
      chk("wprio_first", 32'(req_ready), 32'b0001);
`endif
      tick();
      @(negedge clk);
`ifdef MEM_ARB_WPRIO_EN
      chk("wprio_second", 32'(req_ready), 32'b0001);
`else
      chk("wprio_second", 32'(req_ready), 32'b1000);
`endif
      repeat (10) tick();

      // reset right after a load grant
      do_reset();
      run_mask = '1;
      new_req(1, 1'b0, 15'h0005, '0);
      tick();
      reset = 1'b1;
      new_req(1, 1'b0, 15'h0006, '0);
      new_req(3, 1'b0, 15'h0007, '0);
      tick();
      reset = 1'b0;
      @(negedge clk);
      chk_regs_zero("midreset");
      chk("midreset_next_grant", 32'(req_ready), 32'b0010);
      repeat (12) tick();

      // randomized traffic
      mode = 2;
      run_mask = '1;
      repeat (1500) tick();

      // drain
      mode   = 0;
      pend_v = '0;
      repeat (15) tick();
      chk("drain_issue_queue", 32'(iss_q.size()), 32'd0);
      chk("drain_resp_queue",  32'(rsp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
